// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-register controllers: fetch FSM states,
// instruction-register FunSel encodings and datapath widths.
package fetch_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD_LO = 2'd1,
        ST_RD_HI = 2'd2,
        ST_DONE  = 2'd3
    } fetch_state_e;

    localparam logic [2:0] FS_DEC     = 3'b000;
    localparam logic [2:0] FS_INC     = 3'b001;
    localparam logic [2:0] FS_LOAD    = 3'b010;
    localparam logic [2:0] FS_CLR     = 3'b011;
    localparam logic [2:0] FS_LOAD_LO = 3'b101;
    localparam logic [2:0] FS_LOAD_HI = 3'b110;
    localparam logic [2:0] FS_SEXT    = 3'b111;

    function automatic logic [WORD_W-1:0] zext_byte(input logic [BYTE_W-1:0] b);
        return {{(WORD_W-BYTE_W){1'b0}}, b};
    endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// Per-byte memory wait counter; saturates at TIMEOUT and flags the terminal count.
// Only instantiated by fetch_sequencer when FETCH_TIMEOUT_EN is defined.
module fetch_timeout_counter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic inc_i,
    output logic tc_o
);

    localparam int unsigned CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TC = CW'(TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != TC)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == TC);

endmodule

// File: rtl/fetch_sequencer.sv
// Byte-serial instruction fetch: reads low then high byte and writes them into the IR.
// Optional per-byte read timeout with PC rollback is enabled by defining FETCH_TIMEOUT_EN.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              PcLoad,
    input  logic [WORD_W-1:0] PcIn,
    input  logic [BYTE_W-1:0] MemData,
    input  logic              MemValid,
    output logic              MemRead,
    output logic [WORD_W-1:0] MemAddr,
    output logic [WORD_W-1:0] IR_I,
    output logic              IR_E,
    output logic [2:0]        IR_FunSel,
    output logic [WORD_W-1:0] PC,
    output logic              Busy,
    output logic              Done,
    output logic              Error
);

    fetch_state_e      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] ir_i_q, ir_i_d;
    logic              ir_e_q, ir_e_d;
    logic [2:0]        fs_q, fs_d;
    logic              done_q, done_d;
    logic              reading;

    assign reading = (state_q == ST_RD_LO) || (state_q == ST_RD_HI);

`ifdef FETCH_TIMEOUT_EN
    logic [WORD_W-1:0] start_pc_q, start_pc_d;
    logic              err_q, err_d;
    logic              cnt_clr, cnt_tc;

    // Clear only on the edge that enters a read state, so waits are counted per byte.
    assign cnt_clr = ((state_d == ST_RD_LO) || (state_d == ST_RD_HI)) && (state_d != state_q);

    fetch_timeout_counter #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk_i  (Clock),
        .rst_ni (Reset),
        .clear_i(cnt_clr),
        .inc_i  (reading && !MemValid),
        .tc_o   (cnt_tc)
    );
`else
    if (TIMEOUT == 0) begin : g_timeout_unused
    end
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_i_d  = ir_i_q;
        ir_e_d  = 1'b0;
        fs_d    = FS_LOAD_LO;
        done_d  = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        start_pc_d = start_pc_q;
        err_d      = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (PcLoad) begin
                    pc_d = PcIn;
                end else if (Start) begin
`ifdef FETCH_TIMEOUT_EN
                    start_pc_d = pc_q;
`endif
                    state_d = ST_RD_LO;
                end
            end
            ST_RD_LO, ST_RD_HI: begin
                if (MemValid) begin
                    ir_i_d  = zext_byte(MemData);
                    ir_e_d  = 1'b1;
                    fs_d    = (state_q == ST_RD_LO) ? FS_LOAD_LO : FS_LOAD_HI;
                    pc_d    = pc_q + WORD_W'(1);
                    done_d  = (state_q == ST_RD_HI);
                    state_d = (state_q == ST_RD_LO) ? ST_RD_HI : ST_DONE;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (cnt_tc) begin
                    err_d   = 1'b1;
                    pc_d    = start_pc_q;
                    state_d = ST_IDLE;
                end
`endif
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_i_q  <= '0;
            ir_e_q  <= 1'b0;
            fs_q    <= FS_LOAD_LO;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_i_q  <= ir_i_d;
            ir_e_q  <= ir_e_d;
            fs_q    <= fs_d;
            done_q  <= done_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            start_pc_q <= '0;
            err_q      <= 1'b0;
        end else begin
            start_pc_q <= start_pc_d;
            err_q      <= err_d;
        end
    end

    assign Error = err_q;
`else
    assign Error = 1'b0;
`endif

    assign MemRead   = reading;
    assign MemAddr   = reading ? pc_q : '0;
    assign IR_I      = ir_i_q;
    assign IR_E      = ir_e_q;
    assign IR_FunSel = fs_q;
    assign PC        = pc_q;
    assign Busy      = (state_q != ST_IDLE);
    assign Done      = done_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a byte-array memory model predicts IR writes,
// read addresses, final PC and Done latency; a monitor compares the IR write stream.
module tb_fetch_sequencer;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned TB_TMO = 4;
`else
    localparam int unsigned TB_TMO = 15;
`endif

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic        PcLoad = 1'b0;
    logic [15:0] PcIn = '0;
    logic [7:0]  MemData = '0;
    logic        MemValid = 1'b0;
    logic        MemRead, IR_E, Busy, Done, Error;
    logic [15:0] MemAddr, IR_I, PC;
    logic [2:0]  IR_FunSel;

    always #5 Clock = ~Clock;

    fetch_sequencer #(.TIMEOUT(TB_TMO)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .PcLoad(PcLoad), .PcIn(PcIn),
        .MemData(MemData), .MemValid(MemValid), .MemRead(MemRead), .MemAddr(MemAddr),
        .IR_I(IR_I), .IR_E(IR_E), .IR_FunSel(IR_FunSel), .PC(PC), .Busy(Busy),
        .Done(Done), .Error(Error)
    );

    logic [7:0]  mem [0:65535];
    logic [18:0] exp_wr_q[$];
    logic [15:0] exp_addr_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          ire_count = 0;
    int          done_count = 0;
    int          waits_cfg = 0;
    bit          hold_hi = 1'b0;
    logic [15:0] model_pc = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        n_checks++;
        $display("FAIL %s: got %h with nothing expected", name, act);
    endtask

    // Memory model: waits_cfg wait cycles per byte, stray MemValid pulses when idle.
    initial begin
        int          wcnt = 0;
        bit          lo_served = 1'b0;
        logic [15:0] held = '0;
        forever begin
            @(negedge Clock);
            if (!Reset) begin
                MemValid = 1'b0; wcnt = 0; lo_served = 1'b0;
            end else if (MemRead) begin
                if (wcnt == 0) held = MemAddr;
                else check("addr_stable", MemAddr, held);
                if (wcnt < waits_cfg || (hold_hi && lo_served)) begin
                    MemValid = 1'b0; MemData = 8'($urandom); wcnt++;
                end else begin
                    MemValid = 1'b1; MemData = mem[MemAddr];
                    if (exp_addr_q.size() > 0) check("mem_addr", MemAddr, exp_addr_q.pop_front());
                    else fail_now("unexpected_read", MemAddr);
                    wcnt = 0; lo_served = 1'b1;
                end
            end else begin
                wcnt = 0; lo_served = 1'b0;
                MemValid = ($urandom % 4 == 0); MemData = 8'($urandom);
            end
        end
    end

    // Monitor: every IR write must match the head of the expected-write queue.
    initial begin
        forever begin
            @(negedge Clock);
            if (Reset) begin
                if (IR_E) begin
                    ire_count++;
                    if (exp_wr_q.size() > 0) check("ir_write", {IR_FunSel, IR_I}, exp_wr_q.pop_front());
                    else fail_now("unexpected_ir_write", {IR_FunSel, IR_I});
                end else begin
                    check("idle_funsel", IR_FunSel, 3'b101);
                end
                if (Done) done_count++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic load_pc(input logic [15:0] v);
        @(negedge Clock); PcLoad = 1'b1; PcIn = v;
        @(negedge Clock); PcLoad = 1'b0;
        model_pc = v;
        check("pc_load", PC, v);
    endtask

    task automatic fetch(input int waits, input bit poke);
        int          cyc;
        int          ire0, done0;
        logic [15:0] a1;
        a1 = model_pc + 16'd1;
        waits_cfg = waits;
        exp_wr_q.push_back({3'b101, 8'h00, mem[model_pc]});
        exp_wr_q.push_back({3'b110, 8'h00, mem[a1]});
        exp_addr_q.push_back(model_pc);
        exp_addr_q.push_back(a1);
        model_pc = model_pc + 16'd2;
        ire0 = ire_count; done0 = done_count;
        @(negedge Clock); Start = 1'b1;
        @(negedge Clock); Start = 1'b0;
        cyc = 1;
        check("busy_c1", Busy, 1'b1);
        if (poke) begin Start = 1'b1; PcLoad = 1'b1; PcIn = 16'($urandom); end
        while (Done !== 1'b1 && cyc < 60) begin
            @(negedge Clock); cyc++;
            Start = 1'b0; PcLoad = 1'b0;
        end
        Start = 1'b0; PcLoad = 1'b0;
        check("done_cycle", cyc, 3 + 2 * waits);
        @(negedge Clock);
        check("busy_after", Busy, 1'b0);
        check("pc_after", PC, model_pc);
        check("ir_pulses", ire_count - ire0, 2);
        check("done_pulses", done_count - done0, 1);
        check("error_low", Error, 1'b0);
    endtask

    initial begin
        int d0, cyc, ire0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h0100] = 8'h34;
        mem[16'h0101] = 8'h12;

        repeat (3) @(negedge Clock);
        check("rst_pc", PC, 16'h0000);
        check("rst_busy", Busy, 1'b0);
        check("rst_ire", IR_E, 1'b0);
        check("rst_funsel", IR_FunSel, 3'b101);
        check("rst_ir_i", IR_I, 16'h0000);
        check("rst_done", Done, 1'b0);
        check("rst_memread", MemRead, 1'b0);
        check("rst_error", Error, 1'b0);
        Reset = 1'b1;

        load_pc(16'h0100);
        fetch(0, 1'b0);
        fetch(2, 1'b0);
        load_pc(16'hFFFF);
        fetch(0, 1'b0);

        // PcLoad beats Start in the same cycle.
        @(negedge Clock); PcLoad = 1'b1; Start = 1'b1; PcIn = 16'h4000;
        @(negedge Clock); PcLoad = 1'b0; Start = 1'b0;
        model_pc = 16'h4000;
        check("prio_pc", PC, 16'h4000);
        check("prio_busy", Busy, 1'b0);
        repeat (3) @(negedge Clock);
        check("prio_still_idle", Busy, 1'b0);
        fetch(1, 1'b1);

        for (int i = 0; i < 12; i++) begin
            if ($urandom % 3 == 0) load_pc(($urandom % 2 == 0) ? 16'hFFFE + 16'($urandom % 2) : 16'($urandom));
            fetch(int'($urandom % 4), bit'($urandom % 2));
        end

        // Reset while waiting on the high byte.
        waits_cfg = 3;
        exp_wr_q.push_back({3'b101, 8'h00, mem[model_pc]});
        exp_addr_q.push_back(model_pc);
        @(negedge Clock); Start = 1'b1;
        @(negedge Clock); Start = 1'b0;
        cyc = 1;
        while (IR_E !== 1'b1 && cyc < 30) begin @(negedge Clock); cyc++; end
        check("lo_write_seen", IR_E, 1'b1);
        @(negedge Clock);
        d0 = done_count;
        Reset = 1'b0;
        #1;
        check("mid_rst_pc", PC, 16'h0000);
        check("mid_rst_busy", Busy, 1'b0);
        check("mid_rst_ire", IR_E, 1'b0);
        check("mid_rst_funsel", IR_FunSel, 3'b101);
        check("mid_rst_memread", MemRead, 1'b0);
        check("mid_rst_done", Done, 1'b0);
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
        model_pc = 16'h0000;
        exp_addr_q.delete();
        repeat (4) @(negedge Clock);
        check("mid_rst_no_done", done_count, d0);
        check("mid_rst_idle", Busy, 1'b0);
        check("mid_rst_queue", exp_wr_q.size(), 0);
        fetch(0, 1'b0);

`ifdef FETCH_TIMEOUT_EN
        load_pc(16'h0200);
        waits_cfg = 0;
        hold_hi = 1'b1;
        exp_wr_q.push_back({3'b101, 8'h00, mem[16'h0200]});
        exp_addr_q.push_back(16'h0200);
        ire0 = ire_count;
        @(negedge Clock); Start = 1'b1;
        @(negedge Clock); Start = 1'b0;
        cyc = 1;
        while (Error !== 1'b1 && cyc < 60) begin @(negedge Clock); cyc++; end
        check("tmo_error_cycle", cyc, 7);
        check("tmo_pc", PC, 16'h0200);
        check("tmo_idle", Busy, 1'b0);
        @(negedge Clock);
        check("tmo_error_pulse", Error, 1'b0);
        check("tmo_ir_pulses", ire_count - ire0, 1);
        hold_hi = 1'b0;
        model_pc = 16'h0200;
        fetch(1, 1'b0);
`else
        ire0 = ire_count;
        check("ire_total_nonzero", (ire0 > 0), 1'b1);
`endif

        repeat (2) @(negedge Clock);
        check("final_wr_queue", exp_wr_q.size(), 0);
        check("final_addr_queue", exp_addr_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Byte-serial instruction fetch controller that sits directly upstream of the 16-bit instruction register. It owns the program counter, reads two consecutive bytes from 8-bit memory over a valid-qualified read handshake, and drives the instruction register's `I`, `E` and `FunSel` inputs. The low byte is written with FunSel 101 and the high byte with FunSel 110, so a full instruction word is assembled in place.

## Interface
Parameters:
- `TIMEOUT`, default 15: wait cycles allowed per byte before abort; used only with the timeout feature.

Ports:
- `Clock`  in  1  single system clock; all state changes on the rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `Start`  in  1  fetch request; sampled only in IDLE.
- `PcLoad`  in  1  load PC from `PcIn`; honoured only in IDLE.
- `PcIn`  in  16  new PC value.
- `MemData`  in  8  read data; valid when `MemValid` = 1.
- `MemValid`  in  1  memory read completion for the current `MemAddr`.
- `MemRead`  out  1  read request; held high until `MemValid`.
- `MemAddr`  out  16  read address.
- `IR_I`  out  16  data to the instruction register, always `{8'h00, byte}`.
- `IR_E`  out  1  instruction register enable.
- `IR_FunSel`  out  3  instruction register function select.
- `PC`  out  16  current program counter.
- `Busy`  out  1  high in every state except IDLE.
- `Done`  out  1  one-cycle pulse when the high-byte write is presented.
- `Error`  out  1  one-cycle timeout pulse; tied 0 when the timeout feature is compiled out.

## Operation
- FSM states: IDLE, RD_LO, RD_HI, DONE.
- **IDLE**
  - If `PcLoad` = 1: PC <= `PcIn`. `PcLoad` has priority over `Start` in the same cycle; the load happens and `Start` is ignored.
  - Else if `Start` = 1: save PC as StartPc, go to RD_LO.
- **RD_LO**
  - `MemRead` = 1, `MemAddr` = PC.
  - On an edge with `MemValid` = 1: register `IR_I` = `{8'h00, MemData}`, `IR_FunSel` = 101, `IR_E` = 1; PC <= PC + 1; go to RD_HI.
- **RD_HI**
  - `MemRead` = 1, `MemAddr` = PC.
  - On an edge with `MemValid` = 1: register `IR_I` = `{8'h00, MemData}`, `IR_FunSel` = 110, `IR_E` = 1; PC <= PC + 1; go to DONE.
- **DONE**
  - `Done` = 1 for this one cycle; go to IDLE.
- Outside the write cycles: `IR_E` = 0 and `IR_FunSel` = 101 (harmless value).
- `MemValid` outside RD_LO/RD_HI is ignored.
- Byte order is little-endian: the low byte is at the start address, the high byte at start + 1.
- PC arithmetic is 16-bit modulo: 16'hFFFF + 1 = 16'h0000. A fetch that straddles the wrap reads FFFF then 0000.
- `Start` and `PcLoad` while `Busy` = 1 are ignored; they are not queued.
- Reset, including mid-fetch:
  - All outputs are 0, except `IR_FunSel` = 101.
  - PC = 16'h0000, state = IDLE.
  - A low byte already written to the instruction register stays written; the instruction register itself is not cleared by this block.

## Timing
- `MemRead` and `MemAddr` are Moore outputs decoded from state. `IR_*`, `Done`, `Error` and `PC` are registered.
- Zero-wait memory (`MemValid` high in the first request cycle), `Start` sampled at the end of cycle 0:
  - Cycle 1: RD_LO.
  - Cycle 2: RD_HI, low-byte write presented.
  - Cycle 3: DONE, high-byte write presented, `Done` = 1.
  - The instruction register holds the full word after the edge that ends cycle 3.
  - Cycle 4: IDLE; a new `Start` is accepted at the end of cycle 4.
- Each memory wait cycle adds exactly one cycle of latency.
- `Busy` is high in cycles 1–3 for a zero-wait fetch.

## Configuration
- Macro: `FETCH_TIMEOUT_EN`.
- **Defined**
  - A per-byte wait counter clears on entry to RD_LO and to RD_HI, and increments each cycle while `MemValid` = 0.
  - When the counter reaches `TIMEOUT`: `Error` pulses for one cycle, PC <= StartPc (undoing any low-byte increment), state goes to IDLE, and no further `IR_E` is issued.
  - If `MemValid` arrives in the same cycle the counter reaches `TIMEOUT`, `MemValid` wins.
- **Not defined**
  - The FSM waits indefinitely for `MemValid`.
  - `Error` is constant 0 and the counter logic is absent.

## Structure
- Shared package `fetch_pkg` holds:
  - the FSM state enum;
  - FunSel constants `FS_DEC` = 000, `FS_INC` = 001, `FS_LOAD` = 010, `FS_CLR` = 011, `FS_LOAD_LO` = 101, `FS_LOAD_HI` = 110, `FS_SEXT` = 111, shared with the register and its other controllers;
  - `WORD_W` = 16 and `BYTE_W` = 8.
- One sub-module, `fetch_timeout_counter` (counter plus terminal-count flag, parameterised by `TIMEOUT`), instantiated only under `FETCH_TIMEOUT_EN`.

## Test plan
- Zero-wait fetch: PcLoad 16'h0100, then `Start`; memory [0100] = 34, [0101] = 12 -> writes with FunSel 101 / `IR_I` 0034, then FunSel 110 / `IR_I` 0012; `Done` in cycle 3; PC = 0102.
- Wait states: 2 wait cycles on each byte -> `MemRead` held, `MemAddr` stable, `Done` in cycle 7, exactly two `IR_E` pulses.
- Wrap: PC = FFFF, `Start` -> `MemAddr` FFFF then 0000; PC ends at 0001.
- Priority: `PcLoad` and `Start` in the same cycle, then `Start` while busy -> PC loaded, no fetch starts, the busy-time `Start` is ignored.
- Reset mid-fetch: `Reset` low during RD_HI -> immediate IDLE, PC = 0000, `IR_E` = 0, no `Done`.
- Timeout (macro defined, `TIMEOUT` = 4): PC = 0200, `MemValid` withheld on the high byte -> `Error` pulse after 4 wait cycles, PC = 0200, state IDLE, exactly one `IR_E` pulse issued.
